vip_rgb2ycbcr_cfg: RTL and testbench

//  Parametrised RGB -> YCbCr 4:4:4 colour-space converter for the VIP video pipeline.

---
 rtl/vip_rgb2ycbcr_cfg.sv | 129 ++++++++++++
 tb/tb_vip_rgb2ycbcr_cfg.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_rgb2ycbcr_cfg.sv
// RGB -> YCbCr 4:4:4 converter with four run-time coefficient sets, latched on vsync rise.
// Three-stage pipeline: unsigned products, signed rounded sums, shift/clamp to output.
module vip_rgb2ycbcr_cfg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    cfg_mode,
    input  logic          per_frame_vsync,
    input  logic          per_frame_href,
    input  logic          per_frame_clken,
    input  logic [DW-1:0] per_img_red,
    input  logic [DW-1:0] per_img_green,
    input  logic [DW-1:0] per_img_blue,
    output logic          post_frame_vsync,
    output logic          post_frame_href,
    output logic          post_frame_clken,
    output logic [DW-1:0] post_img_Y,
    output logic [DW-1:0] post_img_Cb,
    output logic [DW-1:0] post_img_Cr,
    output logic [1:0]    cur_mode
);
    localparam int FRAC = 8;
    localparam int PW   = DW + 8;
    localparam int SW   = DW + 11;

    localparam logic signed [SW-1:0] RND     = SW'(1 << (FRAC - 1));
    localparam logic signed [SW-1:0] C_OFF   = SW'(128 << DW);
    localparam logic signed [SW-1:0] Y_OFF_L = SW'(16 << DW);
    localparam logic signed [SW-1:0] MAXV    = SW'((1 << DW) - 1);

    // Coefficient magnitudes; signs are identical in every set (Y +++, Cb --+, Cr +--).
    typedef struct packed {
        logic [7:0] yr, yg, yb;
        logic [7:0] br, bg, bb;
        logic [7:0] rr, rg, rb;
        logic       lim;
    } coef_t;

    function automatic coef_t coef_set(input logic [1:0] m);
        case (m)
            2'd0:    return '{8'd77, 8'd150, 8'd29, 8'd43, 8'd85, 8'd128, 8'd128, 8'd107, 8'd21, 1'b0};
            2'd1:    return '{8'd66, 8'd129, 8'd25, 8'd38, 8'd74, 8'd112, 8'd112, 8'd94,  8'd18, 1'b1};
            2'd2:    return '{8'd54, 8'd183, 8'd19, 8'd29, 8'd99, 8'd128, 8'd128, 8'd116, 8'd12, 1'b0};
            default: return '{8'd47, 8'd157, 8'd16, 8'd26, 8'd87, 8'd112, 8'd112, 8'd102, 8'd10, 1'b1};
        endcase
    endfunction

    function automatic logic signed [SW-1:0] ext(input logic [PW-1:0] v);
        return $signed({3'b000, v});
    endfunction

    function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] q;
        q = s >>> FRAC;
        if (q < 0)         return '0;
        else if (q > MAXV) return '1;
        else               return q[DW-1:0];
    endfunction

    coef_t c;
    assign c = coef_set(cur_mode);

    logic             vsync_d;
    logic [2:0]       vs_r, hr_r, ck_r;
    logic [PW-1:0]    prod [9];
    logic             s1_lim;
    logic signed [SW-1:0] sum_y, sum_cb, sum_cr;

    // NOTE: every register here uses <= so all stages sample the pre-edge values of their
    // predecessors; blocking assignments would collapse the pipeline into fewer stages.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge and clears the product array too, so
        // in-flight pixels from before the reset can never reach the outputs.
        if (!rst_n) begin
            vsync_d     <= 1'b0;
            cur_mode    <= 2'd0;
            vs_r        <= '0;
            hr_r        <= '0;
            ck_r        <= '0;
            for (int i = 0; i < 9; i++) prod[i] <= '0;
            s1_lim      <= 1'b0;
            sum_y       <= '0;
            sum_cb      <= '0;
            sum_cr      <= '0;
            post_img_Y  <= '0;
            post_img_Cb <= '0;
            post_img_Cr <= '0;
        end else begin
            vsync_d <= per_frame_vsync;
            if (per_frame_vsync && !vsync_d) cur_mode <= cfg_mode;

            vs_r <= {vs_r[1:0], per_frame_vsync};
            hr_r <= {hr_r[1:0], per_frame_href};
            ck_r <= {ck_r[1:0], per_frame_clken};

            if (per_frame_clken) begin
                prod[0] <= PW'(per_img_red)   * PW'(c.yr);
                prod[1] <= PW'(per_img_green) * PW'(c.yg);
                prod[2] <= PW'(per_img_blue)  * PW'(c.yb);
                prod[3] <= PW'(per_img_red)   * PW'(c.br);
                prod[4] <= PW'(per_img_green) * PW'(c.bg);
                prod[5] <= PW'(per_img_blue)  * PW'(c.bb);
                prod[6] <= PW'(per_img_red)   * PW'(c.rr);
                prod[7] <= PW'(per_img_green) * PW'(c.rg);
                prod[8] <= PW'(per_img_blue)  * PW'(c.rb);
                s1_lim  <= c.lim;
            end

            if (ck_r[0]) begin
                sum_y  <= ext(prod[0]) + ext(prod[1]) + ext(prod[2])
                          + (s1_lim ? Y_OFF_L : '0) + RND;
                sum_cb <= ext(prod[5]) - ext(prod[3]) - ext(prod[4]) + C_OFF + RND;
                sum_cr <= ext(prod[6]) - ext(prod[7]) - ext(prod[8]) + C_OFF + RND;
            end

            if (ck_r[1]) begin
                post_img_Y  <= sat(sum_y);
                post_img_Cb <= sat(sum_cb);
                post_img_Cr <= sat(sum_cr);
            end
        end
    end

    assign post_frame_vsync = vs_r[2];
    assign post_frame_href  = hr_r[2];
    assign post_frame_clken = ck_r[2];

endmodule

// File: tb/tb_vip_rgb2ycbcr_cfg.sv
// Self-checking bench for vip_rgb2ycbcr_cfg: directed colour cases plus a randomized stream
// compared against a cycle-level reference model built from the coefficient table.
module tb_vip_rgb2ycbcr_cfg;
    localparam int DW = 8;
    localparam int VW = 3 * DW + 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    cfg_mode;
    logic          vs, hr, ck;
    logic [DW-1:0] r, g, b;
    logic          post_frame_vsync, post_frame_href, post_frame_clken;
    logic [DW-1:0] post_img_Y, post_img_Cb, post_img_Cr;
    logic [1:0]    cur_mode;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    vip_rgb2ycbcr_cfg #(.DW(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_mode         (cfg_mode),
        .per_frame_vsync  (vs),
        .per_frame_href   (hr),
        .per_frame_clken  (ck),
        .per_img_red      (r),
        .per_img_green    (g),
        .per_img_blue     (b),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Y       (post_img_Y),
        .post_img_Cb      (post_img_Cb),
        .post_img_Cr      (post_img_Cr),
        .cur_mode         (cur_mode)
    );

    // Reference model: signed coefficients {kR, kG, kB, offset} per mode and channel.
    int coef [4][3][4] = '{
        '{'{77, 150, 29, 0},  '{-43, -85, 128, 128}, '{128, -107, -21, 128}},
        '{'{66, 129, 25, 16}, '{-38, -74, 112, 128}, '{112, -94,  -18, 128}},
        '{'{54, 183, 19, 0},  '{-29, -99, 128, 128}, '{128, -116, -12, 128}},
        '{'{47, 157, 16, 16}, '{-26, -87, 112, 128}, '{112, -102, -10, 128}}
    };

    typedef struct {
        bit vs, hr, ck;
        int y, cb, cr;
    } rec_t;

    rec_t pend[$];
    int   m_mode, held_y, held_cb, held_cr;
    bit   m_vsd;
    logic e_vs, e_hr, e_ck;
    logic [DW-1:0] e_y, e_cb, e_cr;
    logic [1:0]    e_mode;

    function automatic int conv(input int m, input int ch, input int rr, input int gg, input int bb);
        int s;
        s = coef[m][ch][0] * rr + coef[m][ch][1] * gg + coef[m][ch][2] * bb
            + coef[m][ch][3] * (1 << DW) + 128;
        s = s >>> 8;
        if (s < 0) s = 0;
        if (s > (1 << DW) - 1) s = (1 << DW) - 1;
        return s;
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {post_frame_vsync, post_frame_href, post_frame_clken,
                post_img_Y, post_img_Cb, post_img_Cr, cur_mode};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {e_vs, e_hr, e_ck, e_y, e_cb, e_cr, e_mode};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit after it.
    task automatic step(input bit rst, input bit v, input bit h, input bit c,
                        input int rr, input int gg, input int bb, input int cm);
        rec_t n, o;
        rst_n    = !rst;
        vs       = v;
        hr       = h;
        ck       = c;
        r        = DW'(rr);
        g        = DW'(gg);
        b        = DW'(bb);
        cfg_mode = 2'(cm);
        @(posedge clk);
        if (rst) begin
            o = '{0, 0, 0, 0, 0, 0};
            pend.delete();
            pend.push_back(o);
            pend.push_back(o);
            m_mode = 0; m_vsd = 1'b0;
            held_y = 0; held_cb = 0; held_cr = 0;
        end else begin
            n.vs = v; n.hr = h; n.ck = c;
            n.y  = conv(m_mode, 0, rr, gg, bb);
            n.cb = conv(m_mode, 1, rr, gg, bb);
            n.cr = conv(m_mode, 2, rr, gg, bb);
            pend.push_back(n);
            o = pend.pop_front();
            if (o.ck) begin
                held_y = o.y; held_cb = o.cb; held_cr = o.cr;
            end
            if (v && !m_vsd) m_mode = cm;
            m_vsd = v;
        end
        e_vs = o.vs; e_hr = o.hr; e_ck = o.ck;
        e_y  = DW'(held_y); e_cb = DW'(held_cb); e_cr = DW'(held_cr);
        e_mode = 2'(m_mode);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        assertions++;
        if (dut_vec() !== '0) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), {VW{1'b0}});
        end
    endtask

    task automatic test_white_m0();
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 255, 255, 255, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        assertions++;
        if ({post_frame_clken, post_img_Y, post_img_Cb, post_img_Cr} !== {1'b1, 8'd255, 8'd128, 8'd128}) begin
            failures++;
            $display("FAIL white_m0: got clken=%0d Y=%0d Cb=%0d Cr=%0d expected 1 255 128 128",
                     post_frame_clken, post_img_Y, post_img_Cb, post_img_Cr);
        end
    endtask

    task automatic test_limited();
        step(0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 255, 255, 255, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        assertions++;
        if ({post_img_Y, post_img_Cb, post_img_Cr, cur_mode} !== {8'd16, 8'd128, 8'd128, 2'd1}) begin
            failures++;
            $display("FAIL limited_black: got Y=%0d Cb=%0d Cr=%0d mode=%0d expected 16 128 128 1",
                     post_img_Y, post_img_Cb, post_img_Cr, cur_mode);
        end
        step(0, 0, 1, 0, 0, 0, 0, 0);
        assertions++;
        if ({post_img_Y, post_img_Cb, post_img_Cr} !== {8'd235, 8'd128, 8'd128}) begin
            failures++;
            $display("FAIL limited_white: got Y=%0d Cb=%0d Cr=%0d expected 235 128 128",
                     post_img_Y, post_img_Cb, post_img_Cr);
        end
    endtask

    task automatic test_saturation();
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 255, 0, 0, 3);
        step(0, 0, 1, 0, 0, 0, 0, 3);
        step(0, 0, 1, 0, 0, 0, 0, 3);
        assertions++;
        if ({post_img_Y, post_img_Cb, post_img_Cr} !== {8'd77, 8'd85, 8'd255}) begin
            failures++;
            $display("FAIL saturation_red: got Y=%0d Cb=%0d Cr=%0d expected 77 85 255",
                     post_img_Y, post_img_Cb, post_img_Cr);
        end
    endtask

    task automatic test_mode_switch();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 10, 20, 30, 0);
        step(0, 1, 1, 1, 255, 255, 255, 1);
        step(0, 1, 1, 1, 255, 255, 255, 1);
        step(0, 1, 1, 0, 0, 0, 0, 1);
        assertions++;
        if (cur_mode !== 2'd0) begin
            failures++;
            $display("FAIL midframe_mode_hold: got %0d expected 0", cur_mode);
        end
        assertions++;
        if (post_img_Y !== 8'd255) begin
            failures++;
            $display("FAIL midframe_white_m0: got Y=%0d expected 255", post_img_Y);
        end
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 1);
        assertions++;
        if (cur_mode !== 2'd1) begin
            failures++;
            $display("FAIL vsync_rise_latch: got %0d expected 1", cur_mode);
        end
        step(0, 1, 1, 1, 255, 255, 255, 2);
        step(0, 1, 1, 0, 0, 0, 0, 2);
        step(0, 1, 1, 0, 0, 0, 0, 2);
        assertions++;
        if (post_img_Y !== 8'd235) begin
            failures++;
            $display("FAIL new_mode_white: got Y=%0d expected 235", post_img_Y);
        end
    endtask

    task automatic test_clken_gaps();
        bit pat [8] = '{1, 0, 1, 0, 1, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, pat[i], 40 * i + 3, 250 - 30 * i, 17 * i, 0);
            assertions++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL clken_gap[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 200, 100, 50 + i, 0);
        step(1, 0, 1, 1, 9, 9, 9, 0);
        assertions++;
        if (dut_vec() !== '0) begin
            failures++;
            $display("FAIL reset_mid_zero: got %h expected %h", dut_vec(), {VW{1'b0}});
        end
        step(0, 1, 0, 0, 0, 0, 0, 3);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 1, 30 * i, 255 - 20 * i, 128, 0);
            assertions++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_resume[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) v = !v;
            step(0, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
            assertions++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_mode = '0; vs = 1'b0; hr = 1'b0; ck = 1'b0;
        r = '0; g = '0; b = '0;
        test_reset();
        test_white_m0();
        test_limited();
        test_saturation();
        test_mode_switch();
        test_clken_gaps();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
